// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: buffers host read/write commands in a small FIFO and
// feeds them one at a time to an APB master's system-task interface.
// It waits for the master's completion or error, or for its own watchdog,
// and then returns exactly one in-order response per command.
module apb_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 64
) (
  input  logic                     apb_clk,
  input  logic                     apb_reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  input  logic                     cmd_write,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic                     rsp_write,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               rsp_err,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data,
  output logic                     data_dir,
  output logic                     data_valid,
  input  logic                     transaction_done,
  input  logic [DATA_W-1:0]        read_out_data,
  input  logic                     apb_tranerr,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WD_W  = $clog2(WAIT_LIMIT) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WAIT_LIMIT - 1);

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_APB = 2'd1;
  localparam logic [1:0] ERR_WD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fifo_addr  [DEPTH];
  logic [DATA_W-1:0]   r_fifo_wdata [DEPTH];
  logic                r_fifo_write [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [WD_W-1:0]     r_wd_cnt;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_dir;
  logic                r_data_valid;
  logic                r_rsp_valid;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic                r_rsp_write;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_err;

  logic                w_ready;
  logic                w_push;
  logic                w_pop;

  // Ready depends only on the registered occupancy, so the host sees no
  // combinational path from anything else in the block.
  assign w_ready = (r_count != FULL_CNT);
  assign w_push  = cmd_valid & w_ready;
  // The sequencer only takes a new command once the previous response is gone.
  assign w_pop   = (r_state == S_IDLE) && (r_count != {CNT_W{1'b0}});

  // FIFO storage: written on every accepted command; no reset needed since
  // occupancy tracking alone decides which entries are live.
  always_ff @(posedge apb_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr]  <= cmd_addr;
      r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
      r_fifo_write[r_wr_ptr] <= cmd_write;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge apb_clk) begin
    if (!apb_reset_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue/response sequencer with all master-side and host-side outputs registered.
  always_ff @(posedge apb_clk) begin
    if (!apb_reset_n) begin
      r_state      <= S_IDLE;
      r_wd_cnt     <= {WD_W{1'b0}};
      r_addr       <= {ADDR_W{1'b0}};
      r_data       <= {DATA_W{1'b0}};
      r_dir        <= 1'b0;
      r_data_valid <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_addr   <= {ADDR_W{1'b0}};
      r_rsp_write  <= 1'b0;
      r_rsp_rdata  <= {DATA_W{1'b0}};
      r_rsp_err    <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_addr       <= r_fifo_addr[r_rd_ptr];
            r_data       <= r_fifo_write[r_rd_ptr] ? r_fifo_wdata[r_rd_ptr] : {DATA_W{1'b0}};
            r_dir        <= r_fifo_write[r_rd_ptr];
            r_data_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // One-cycle request pulse, so the master cannot re-trigger later.
          r_data_valid <= 1'b0;
          r_wd_cnt     <= {WD_W{1'b0}};
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_wd_cnt <= r_wd_cnt + WD_W'(1);
          if (transaction_done) begin
            r_rsp_rdata <= r_dir ? {DATA_W{1'b0}} : read_out_data;
            r_rsp_err   <= ERR_OK;
            r_rsp_addr  <= r_addr;
            r_rsp_write <= r_dir;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (apb_tranerr) begin
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= ERR_APB;
            r_rsp_addr  <= r_addr;
            r_rsp_write <= r_dir;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_wd_cnt == WD_LAST) begin
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= ERR_WD;
            r_rsp_addr  <= r_addr;
            r_rsp_write <= r_dir;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_data_valid <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = w_ready;
  assign cmd_count  = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != {CNT_W{1'b0}});
  assign addr       = r_addr;
  assign data       = r_data;
  assign data_dir   = r_dir;
  assign data_valid = r_data_valid;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_write  = r_rsp_write;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with a small APB master model
// (a memory that answers after a programmable delay, or errors, or stalls).
`timescale 1ns/1ps
module tb_apb_cmd_sequencer;
  localparam int DEPTH      = 4;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int WAIT_LIMIT = 64;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic              apb_clk = 1'b0;
  logic              apb_reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = 8'h00;
  logic [DATA_W-1:0] cmd_wdata = 32'h0;
  logic              cmd_write = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              data_dir;
  logic              data_valid;
  logic              transaction_done;
  logic [DATA_W-1:0] read_out_data;
  logic              apb_tranerr;
  logic [CNT_W-1:0]  cmd_count;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // master model controls (written by the main thread only)
  int   m_delay = 0;
  logic m_hold  = 1'b0;
  logic m_flush = 1'b0;
  int   err_req = 0;
  // master model state (written by the master thread only)
  int   err_done  = 0;
  int   issue_cnt = 0;
  int   dv_err    = 0;
  logic [DATA_W-1:0] mem [256];

  apb_cmd_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .apb_clk(apb_clk), .apb_reset_n(apb_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .data(data), .data_dir(data_dir), .data_valid(data_valid),
    .transaction_done(transaction_done), .read_out_data(read_out_data),
    .apb_tranerr(apb_tranerr), .cmd_count(cmd_count), .busy(busy)
  );

  always #5 apb_clk = ~apb_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // APB master model: acts on negedges, answers m_delay WAIT cycles after the request.
  initial begin
    int   wait_cnt;
    logic pend;
    logic dv_prev;
    wait_cnt = 0; pend = 1'b0; dv_prev = 1'b0;
    transaction_done = 1'b0; apb_tranerr = 1'b0; read_out_data = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    forever begin
      @(negedge apb_clk);
      transaction_done = 1'b0;
      apb_tranerr      = 1'b0;
      read_out_data    = 32'h0;
      if (m_flush) pend = 1'b0;
      if (data_valid) begin
        issue_cnt++;
        if (dv_prev) dv_err++;
        pend = 1'b1;
        wait_cnt = 0;
      end else if (pend && !m_hold) begin
        if (wait_cnt >= m_delay) begin
          if (err_req != err_done) begin
            apb_tranerr = 1'b1;
            err_done++;
          end else begin
            transaction_done = 1'b1;
            if (data_dir) mem[addr] = data;
            else read_out_data = mem[addr];
          end
          pend = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
      dv_prev = data_valid;
    end
  end

  task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    while (!cmd_ready && n < 300) begin @(negedge apb_clk); n++; end
    check_eq({tag, "_accept"}, cmd_ready, 1'b1);
    @(negedge apb_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push(input string tag, input logic w, input logic [7:0] a, input logic [31:0] d);
    drive_cmd(w, a, d);
    wait_accept(tag);
  endtask

  task automatic get_rsp(input string tag, input logic [7:0] ea, input logic ew,
                         input logic [31:0] ed, input logic [1:0] ee, input int bp);
    int n = 0;
    int diffs = 0;
    int ic;
    while (!rsp_valid && n < 300) begin @(negedge apb_clk); n++; end
    check_eq({tag, "_valid"}, rsp_valid, 1'b1);
    check_eq({tag, "_addr"},  rsp_addr,  ea);
    check_eq({tag, "_write"}, rsp_write, ew);
    check_eq({tag, "_rdata"}, rsp_rdata, ed);
    check_eq({tag, "_err"},   rsp_err,   ee);
    ic = issue_cnt;
    for (int i = 0; i < bp; i++) begin
      @(negedge apb_clk);
      if (rsp_valid !== 1'b1 || rsp_addr !== ea || rsp_write !== ew ||
          rsp_rdata !== ed || rsp_err !== ee || data_valid !== 1'b0) diffs++;
    end
    if (bp > 0) begin
      check_eq({tag, "_stable"},  diffs, 0);
      check_eq({tag, "_noissue"}, issue_cnt, ic);
    end
    rsp_ready = 1'b1;
    @(negedge apb_clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int n;
    int ic;
    int late_rsp;

    // ---- reset ----
    repeat (3) @(negedge apb_clk);
    apb_reset_n = 1'b1;
    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_count", cmd_count, 3'd0);
    check_eq("rst_dv",    data_valid, 1'b0);
    check_eq("rst_rspv",  rsp_valid, 1'b0);
    check_eq("rst_busy",  busy, 1'b0);
    check_eq("rst_addr",  addr, 8'h00);
    check_eq("rst_data",  data, 32'h0);
    check_eq("rst_err",   rsp_err, 2'd0);

    // ---- write then read ----
    m_delay = 2;
    push("t1_c0", 1'b1, 8'h04, 32'd10);
    push("t1_c1", 1'b0, 8'h04, 32'hDEAD_BEEF);
    get_rsp("t1_wr", 8'h04, 1'b1, 32'd0, 2'd0, 0);
    get_rsp("t1_rd", 8'h04, 1'b0, 32'd10, 2'd0, 0);
    check_eq("t1_rd_data_zero", data, 32'h0);
    check_eq("t1_issues", issue_cnt, 2);

    // ---- FIFO full with master stalled ----
    m_hold = 1'b1; m_delay = 1;
    push("t2_c0", 1'b1, 8'h10, 32'hA0);
    push("t2_c1", 1'b1, 8'h11, 32'hA1);
    push("t2_c2", 1'b1, 8'h12, 32'hA2);
    push("t2_c3", 1'b0, 8'h10, 32'h0);
    push("t2_c4", 1'b0, 8'h11, 32'h0);
    check_eq("t2_full_count", cmd_count, 3'd4);
    check_eq("t2_full_ready", cmd_ready, 1'b0);
    drive_cmd(1'b0, 8'h12, 32'h0);
    repeat (3) @(negedge apb_clk);
    check_eq("t2_blocked_count", cmd_count, 3'd4);
    m_hold = 1'b0;
    get_rsp("t2_r0", 8'h10, 1'b1, 32'h0, 2'd0, 0);
    wait_accept("t2_c5");
    get_rsp("t2_r1", 8'h11, 1'b1, 32'h0, 2'd0, 0);
    get_rsp("t2_r2", 8'h12, 1'b1, 32'h0, 2'd0, 0);
    get_rsp("t2_r3", 8'h10, 1'b0, 32'hA0, 2'd0, 0);
    get_rsp("t2_r4", 8'h11, 1'b0, 32'hA1, 2'd0, 0);
    get_rsp("t2_r5", 8'h12, 1'b0, 32'hA2, 2'd0, 0);

    // ---- response backpressure ----
    m_delay = 1;
    push("t3_c0", 1'b1, 8'h20, 32'h55);
    push("t3_c1", 1'b0, 8'h20, 32'h0);
    get_rsp("t3_r0", 8'h20, 1'b1, 32'h0, 2'd0, 10);
    check_eq("t3_idle_dv", data_valid, 1'b0);
    @(negedge apb_clk);
    check_eq("t3_next_dv",   data_valid, 1'b1);
    check_eq("t3_next_addr", addr, 8'h20);
    check_eq("t3_next_dir",  data_dir, 1'b0);
    get_rsp("t3_r1", 8'h20, 1'b0, 32'h55, 2'd0, 0);

    // ---- APB transfer error then a normal command ----
    m_delay = 0;
    err_req++;
    push("t4_c0", 1'b1, 8'h30, 32'h77);
    push("t4_c1", 1'b0, 8'h10, 32'h0);
    get_rsp("t4_r0", 8'h30, 1'b1, 32'h0, 2'd1, 0);
    get_rsp("t4_r1", 8'h10, 1'b0, 32'hA0, 2'd0, 0);

    // ---- watchdog ----
    m_hold = 1'b1; m_delay = 2;
    push("t5_c0", 1'b0, 8'h40, 32'h0);
    n = 0;
    while (!data_valid && n < 20) begin @(negedge apb_clk); n++; end
    check_eq("t5_issue", data_valid, 1'b1);
    @(negedge apb_clk);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge apb_clk); n++; end
    check_eq("t5_wd_cycles", n, WAIT_LIMIT);
    get_rsp("t5_r0", 8'h40, 1'b0, 32'h0, 2'd2, 0);
    ic = issue_cnt;
    m_hold = 1'b0;
    late_rsp = 0;
    repeat (10) begin
      @(negedge apb_clk);
      if (rsp_valid) late_rsp++;
    end
    check_eq("t5_late_rsp",  late_rsp, 0);
    check_eq("t5_late_iss",  issue_cnt, ic);
    check_eq("t5_late_busy", busy, 1'b0);

    // ---- reset mid-WAIT with three queued ----
    m_hold = 1'b1;
    push("t6_c0", 1'b1, 8'h50, 32'h1);
    push("t6_c1", 1'b1, 8'h51, 32'h2);
    push("t6_c2", 1'b1, 8'h52, 32'h3);
    push("t6_c3", 1'b1, 8'h53, 32'h4);
    check_eq("t6_pre_count", cmd_count, 3'd3);
    check_eq("t6_pre_busy",  busy, 1'b1);
    m_flush = 1'b1;
    apb_reset_n = 1'b0;
    @(negedge apb_clk);
    apb_reset_n = 1'b1;
    check_eq("t6_count", cmd_count, 3'd0);
    check_eq("t6_dv",    data_valid, 1'b0);
    check_eq("t6_rspv",  rsp_valid, 1'b0);
    check_eq("t6_busy",  busy, 1'b0);
    check_eq("t6_ready", cmd_ready, 1'b1);
    check_eq("t6_addr",  addr, 8'h00);
    repeat (2) @(negedge apb_clk);
    m_flush = 1'b0;
    m_hold  = 1'b0;
    check_eq("t6_still_idle", busy, 1'b0);
    push("t6_c4", 1'b0, 8'h10, 32'h0);
    get_rsp("t6_r0", 8'h10, 1'b0, 32'hA0, 2'd0, 0);

    check_eq("dv_single_pulse", dv_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
